// File: rtl/router_pkg.sv
// Shared definitions for the router output-port blocks: header field
// positions, payload limits and the sink FSM state encoding.
package router_pkg;

  localparam int HDR_LEN_MSB      = 7;
  localparam int HDR_LEN_LSB      = 2;
  localparam int HDR_ADDR_W       = 2;
  localparam int MAX_PAYLOAD      = 63;
  localparam int SOFT_RST_TIMEOUT = 30;

  // Width of the header length field (6 bits covers 0..MAX_PAYLOAD).
  localparam int LEN_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_HDR     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_DONE    = 3'd5
  } sink_state_e;

  // Payload length carried in a header byte.
  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  // Destination port address carried in a header byte.
  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_sat_cnt.sv
// Saturating up-counter: advances by one on each inc pulse and sticks at
// all-ones instead of wrapping.
module router_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register, held once it reaches its maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      // NOTE: registers take non-blocking assignments so every flop in the
      // design updates from values sampled before the clock edge.
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/router_port_sink.sv
// Downstream consumer for one router output port. Drains the port FIFO,
// splits each packet into header / payload / parity, checks parity and the
// destination address, and keeps saturating packet and error counts.
module router_port_sink
  import router_pkg::*;
#(
  parameter logic [1:0] PORT_ID   = 2'd0,
  parameter int         STALL_MAX = 255,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       rd_delay,
  input  logic             vld_out,
  input  logic [7:0]       dout,
  output logic             rd_en,
  output logic             byte_vld,
  output logic [7:0]       byte_data,
  output logic             pkt_done,
  output logic [5:0]       pkt_len,
  output logic             par_err,
  output logic             addr_err,
  output logic             abort,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int                 STALL_W    = $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

  sink_state_e        state, state_nxt;
  logic [5:0]         dly_cnt;
  logic               rd_pend;       // a read issued last cycle returns on dout now
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   reads_issued;
  logic [LEN_W-1:0]   bytes_left;
  logic               addr_mis;
  logic [7:0]         par_acc;
  logic [STALL_W-1:0] stall_cnt;

  logic               in_pkt;
  logic               stall_hit;
  logic               done_entry;
  logic               nxt_par_err;
  logic               nxt_abort;
  logic               err_inc;

  // Stall tracking only applies while a packet is being pulled from the FIFO.
  assign in_pkt    = (state == ST_HDR) || (state == ST_PAYLOAD) || (state == ST_PARITY);
  assign stall_hit = in_pkt && en && !vld_out && !rd_pend && (stall_cnt == STALL_LAST);

  // Next-state, read strobe and end-of-packet status decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch
    // leaves one unassigned and no latch is inferred.
    state_nxt   = state;
    rd_en       = 1'b0;
    nxt_par_err = 1'b0;
    nxt_abort   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (en && vld_out) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // The FIFO emptying here means the router soft-reset it: drop quietly.
        if (!vld_out)            state_nxt = ST_IDLE;
        else if (dly_cnt == 6'd0) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        rd_en = en && vld_out && !rd_pend;
        if (rd_pend) state_nxt = (hdr_len(dout) == '0) ? ST_PARITY : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        rd_en = en && vld_out && (reads_issued < len_r);
        if (rd_pend && (bytes_left == LEN_W'(1))) state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        rd_en = en && vld_out && !rd_pend;
        if (rd_pend) begin
          state_nxt   = ST_DONE;
          nxt_par_err = (par_acc != dout);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A writer that went silent too long ends the packet as aborted.
    if (stall_hit) begin
      state_nxt   = ST_DONE;
      rd_en       = 1'b0;
      nxt_par_err = 1'b0;
      nxt_abort   = 1'b1;
    end
  end

  assign done_entry = (state_nxt == ST_DONE) && (state != ST_DONE);
  assign err_inc    = done_entry && (nxt_par_err || addr_mis || nxt_abort);

  // FSM state register and read-in-flight flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rd_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_en;
    end
  end

  // First-read hold-off: loaded while idle, counted down in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_cnt <= '0;
    end else if (state == ST_IDLE) begin
      dly_cnt <= rd_delay;
    end else if ((state == ST_WAIT) && (dly_cnt != 6'd0)) begin
      dly_cnt <= dly_cnt - 6'd1;
    end
  end

  // Header capture, payload read tracking and running parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r        <= '0;
      addr_mis     <= 1'b0;
      par_acc      <= '0;
      reads_issued <= '0;
      bytes_left   <= '0;
    end else begin
      unique case (state)
        ST_WAIT: begin
          // Clear per-packet context so an early abort reports no header data.
          len_r        <= '0;
          addr_mis     <= 1'b0;
          par_acc      <= '0;
          reads_issued <= '0;
          bytes_left   <= '0;
        end
        ST_HDR: begin
          if (rd_pend) begin
            len_r        <= hdr_len(dout);
            addr_mis     <= (hdr_addr(dout) != PORT_ID);
            par_acc      <= dout;
            bytes_left   <= hdr_len(dout);
            reads_issued <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (rd_en) reads_issued <= reads_issued + LEN_W'(1);
          if (rd_pend) begin
            par_acc    <= par_acc ^ dout;
            bytes_left <= bytes_left - LEN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Consecutive idle-cycle counter; frozen while the sink is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!in_pkt || rd_pend) begin
      stall_cnt <= '0;
    end else if (en && !vld_out) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  // Payload byte stream: one registered pulse per returned payload byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_vld  <= 1'b0;
      byte_data <= '0;
    end else begin
      byte_vld <= (state == ST_PAYLOAD) && rd_pend;
      if ((state == ST_PAYLOAD) && rd_pend) byte_data <= dout;
    end
  end

  // Packet status, updated on entry to DONE so it is valid with pkt_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      par_err  <= 1'b0;
      addr_err <= 1'b0;
      abort    <= 1'b0;
    end else begin
      pkt_done <= done_entry;
      if (done_entry) begin
        pkt_len  <= len_r;
        par_err  <= nxt_par_err;
        addr_err <= addr_mis;
        abort    <= nxt_abort;
      end
    end
  end

  router_sat_cnt #(.W(CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (done_entry),
    .cnt   (pkt_cnt)
  );

  router_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (err_inc),
    .cnt   (err_cnt)
  );

endmodule
